// File: rtl/cla_test_pkg.sv
// cla_test_pkg: shared width, sweep FSM states and the golden adder for the CLA self-test.
package cla_test_pkg;
   localparam int CLA_WIDTH = 5;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   // 32-bit wide so any operand width fits; callers truncate to WIDTH+1 bits.
   function automatic logic [31:0] golden_add(input logic [31:0] x, input logic [31:0] y);
      return x + y;
   endfunction
endpackage

// File: rtl/cla_sweep_checker.sv
// cla_sweep_checker: sweeps every operand pair into the adder, holds each for DWELL
// cycles and counts results that differ from golden a+b.
module cla_sweep_checker
   import cla_test_pkg::*;
#(
   parameter int WIDTH   = CLA_WIDTH,
   parameter int LATENCY = 1,
   parameter int DWELL   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   sum_in,
   input  logic               cout_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b,
   output logic               fail_seen
);
   localparam int IW = 2 * WIDTH;
   localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
   generate
      if (DWELL <= LATENCY) begin : g_bad_dwell
         $error("cla_sweep_checker: DWELL must exceed LATENCY");
      end
   endgenerate
   state_t        state, state_nxt;
   logic [IW-1:0] idx;
   logic [DW-1:0] dwell;
   logic          sweep_go, last_dwell, last_vec, cmp, mism;
   logic [IW:0]   err_nxt;
   assign a = idx[IW-1:WIDTH];
   assign b = idx[WIDTH-1:0];
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   always_comb begin
      state_nxt = sweep_go ? RUN : (state == RUN && last_dwell && last_vec) ? DONE : state;
   end
   always_comb begin
      sweep_go   = start && state != RUN;
      last_dwell = dwell == DW'(DWELL - 1);
      last_vec   = &idx;
      cmp        = state == RUN && dwell == DW'(LATENCY);
      mism       = {cout_in, sum_in} != (WIDTH + 1)'(golden_add(32'(a), 32'(b)));
      err_nxt    = cmp && mism ? err_count + (IW + 1)'(1) : err_count;
   end
   // pass uses err_nxt so a compare in the final dwell cycle is still counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         dwell     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_a    <= '0;
         fail_b    <= '0;
         fail_seen <= 1'b0;
      end else begin
         busy <= state_nxt == RUN;
         done <= state_nxt == DONE;
         pass <= state_nxt == DONE && err_nxt == '0;
         if (sweep_go) begin
            idx       <= '0;
            dwell     <= '0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_seen <= 1'b0;
         end else if (state == RUN) begin
            err_count <= err_nxt;
            if (cmp && mism && !fail_seen) begin
               fail_a    <= a;
               fail_b    <= b;
               fail_seen <= 1'b1;
            end
            dwell <= last_dwell ? '0 : dwell + 1'b1;
            if (last_dwell && !last_vec) idx <= idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cla_sweep_checker.sv
// tb_cla_sweep_checker: drives sweeps against behavioural adder models and scores each
// completed sweep against expectations queued when the sweep was started.
module tb_cla_sweep_checker;
   import cla_test_pkg::*;
   typedef struct {
      int lo;
      int hi;
      bit pass;
      bit fseen;
      bit fchk;
      int fa;
      int fb;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, start1 = 1'b0, start2 = 1'b0;
   logic [4:0] a1, b1, sum1, a2, b2, sum2, fa1, fb1, fa2, fb2;
   logic cout1, cout2, busy1, done1, pass1, fs1, busy2, done2, pass2, fs2;
   logic [10:0] err1, err2;
   logic [5:0] p1 = '0, p1d = '0, p2 = '0, p2d = '0;
   int mode = 0;
   bit lat2 = 1'b0;
   int total = 0, bad = 0;
   exp_t q1[$], q2[$];
   int blen1 = 0, blen2 = 0;
   logic pb1 = 1'b0, pd1 = 1'b0, pb2 = 1'b0, pd2 = 1'b0;
   always #5 clk = ~clk;
   cla_sweep_checker #(.WIDTH(5), .LATENCY(1), .DWELL(4)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .sum_in(sum1), .cout_in(cout1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_a(fa1), .fail_b(fb1),
      .fail_seen(fs1));
   cla_sweep_checker #(.WIDTH(5), .LATENCY(2), .DWELL(4)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .sum_in(sum2), .cout_in(cout2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_a(fa2), .fail_b(fb2),
      .fail_seen(fs2));
   // mode 0: correct, 1: sum[0] stuck at 0, 2: cout inverted only for 31+31
   function automatic logic [5:0] model(input logic [4:0] x, input logic [4:0] y, input int m);
      logic [5:0] r;
      r = {1'b0, x} + {1'b0, y};
      if (m == 1) r[0] = 1'b0;
      if (m == 2 && x == 5'd31 && y == 5'd31) r[5] = ~r[5];
      return r;
   endfunction
   always @(posedge clk) begin
      p1  <= model(a1, b1, mode);
      p1d <= p1;
      p2  <= model(a2, b2, 0);
      p2d <= p2;
   end
   assign {cout1, sum1} = lat2 ? p1d : p1;
   assign {cout2, sum2} = p2d;
   function automatic void chk(input string n, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d", n, got, exp);
      end
   endfunction
   task automatic check_sweep(input string tag, input exp_t e, input int blen, input logic ps,
                              input int err, input logic fs, input int fa, input int fb,
                              input int av, input int bv);
      chk({tag, "_busy_len"}, blen, 4096);
      chk({tag, "_pass"}, int'(ps), int'(e.pass));
      if (e.lo == e.hi) chk({tag, "_err_count"}, err, e.lo);
      else begin
         total++;
         if (err < e.lo || err > e.hi) begin
            bad++;
            $display("FAIL %s_err_range got=%0d expected=%0d..%0d", tag, err, e.lo, e.hi);
         end
      end
      chk({tag, "_fail_seen"}, int'(fs), int'(e.fseen));
      if (e.fchk) begin
         chk({tag, "_fail_a"}, fa, e.fa);
         chk({tag, "_fail_b"}, fb, e.fb);
      end
      chk({tag, "_done_a"}, av, 31);
      chk({tag, "_done_b"}, bv, 31);
   endtask
   always @(posedge clk) begin
      #1;
      if (busy1) blen1 = pb1 ? blen1 + 1 : 1;
      if (busy2) blen2 = pb2 ? blen2 + 1 : 1;
      if (done1 && !pd1) begin
         if (q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut1_unexpected_done got=1 expected=0");
         end else
            check_sweep("dut1", q1.pop_front(), blen1, pass1, int'(err1), fs1, int'(fa1),
                        int'(fb1), int'(a1), int'(b1));
      end
      if (done2 && !pd2) begin
         if (q2.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut2_unexpected_done got=1 expected=0");
         end else
            check_sweep("dut2", q2.pop_front(), blen2, pass2, int'(err2), fs2, int'(fa2),
                        int'(fb2), int'(a2), int'(b2));
      end
      pb1 = busy1;
      pd1 = done1;
      pb2 = busy2;
      pd2 = done2;
   end
   task automatic pulse(input bit s1, input bit s2);
      @(negedge clk);
      start1 = s1;
      start2 = s2;
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
   endtask
   task automatic wait_drain(input string tag);
      int n = 0;
      while ((q1.size() != 0 || q2.size() != 0) && n < 6000) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (q1.size() != 0 || q2.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s_timeout got=%0d expected=0 pending sweeps", tag, q1.size() + q2.size());
         q1.delete();
         q2.delete();
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_a"}, int'(a1), 0);
      chk({tag, "_b"}, int'(b1), 0);
      chk({tag, "_busy"}, int'(busy1), 0);
      chk({tag, "_done"}, int'(done1), 0);
      chk({tag, "_pass"}, int'(pass1), 0);
      chk({tag, "_err_count"}, int'(err1), 0);
      chk({tag, "_fail_a"}, int'(fa1), 0);
      chk({tag, "_fail_b"}, int'(fb1), 0);
      chk({tag, "_fail_seen"}, int'(fs1), 0);
      chk({tag, "_state_idle"}, int'(dut1.state == IDLE), 1);
   endtask
   initial begin
      int n;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      chk_reset("por");
      @(negedge clk);
      rst = 1'b0;
      // clean sweep with ignored start pulses near busy cycles 10 and 2000
      q1.push_back('{0, 0, 1'b1, 1'b0, 1'b0, 0, 0});
      pulse(1'b1, 1'b0);
      repeat (8) @(negedge clk);
      pulse(1'b1, 1'b0);
      repeat (1988) @(negedge clk);
      pulse(1'b1, 1'b0);
      wait_drain("clean");
      mode = 1;
      q1.push_back('{512, 512, 1'b0, 1'b1, 1'b1, 0, 1});
      pulse(1'b1, 1'b0);
      wait_drain("stuck_sum0");
      // restart from a failing DONE: diagnostics must clear right away
      mode = 2;
      q1.push_back('{1, 1, 1'b0, 1'b1, 1'b1, 31, 31});
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      chk("restart_err_count", int'(err1), 0);
      chk("restart_fail_seen", int'(fs1), 0);
      chk("restart_busy", int'(busy1), 1);
      chk("restart_done", int'(done1), 0);
      @(negedge clk);
      start1 = 1'b0;
      wait_drain("cout_3131");
      mode = 0;
      pulse(1'b1, 1'b0);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(a1 == 5'd9 && b1 == 5'd12) && n < 5000);
      chk("reach_9_12", int'(a1 == 5'd9 && b1 == 5'd12), 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset("midrst");
      @(negedge clk);
      rst = 1'b0;
      q1.push_back('{0, 0, 1'b1, 1'b0, 1'b0, 0, 0});
      pulse(1'b1, 1'b0);
      wait_drain("after_rst");
      // latency-2 adder: mis-timed checker must fail, matched checker must pass
      lat2 = 1'b1;
      q1.push_back('{1, 1024, 1'b0, 1'b1, 1'b0, 0, 0});
      q2.push_back('{0, 0, 1'b1, 1'b0, 1'b0, 0, 0});
      pulse(1'b1, 1'b1);
      wait_drain("latency2");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
